// File: rtl/requant_pipe_if.sv
// Stream/gain-RAM bundle for requant_pipe: input sample stream, gain RAM
// read port and requantised output stream.
interface requant_pipe_if #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 8,
    parameter int GAIN_W = 5,
    parameter int ADDR_W = 11
);
    logic                ce;
    logic                arm;
    logic                sync_in;
    logic [2*IN_W-1:0]   data_in;
    logic [GAIN_W-1:0]   gain;
    logic [ADDR_W-1:0]   gain_addr;
    logic [2*OUT_W-1:0]  data_out;
    logic                data_valid;
    logic                sync_out;
    logic                overflow;
    logic [ADDR_W:0]     ovf_count;

    modport master (
        output ce, arm, sync_in, data_in, gain,
        input  gain_addr, data_out, data_valid, sync_out, overflow, ovf_count
    );

    modport slave (
        input  ce, arm, sync_in, data_in, gain,
        output gain_addr, data_out, data_valid, sync_out, overflow, ovf_count
    );
endinterface

// File: rtl/requant_pipe.sv
// requant_pipe: per-channel gain multiply, round-half-up, symmetric saturate.
// Define REQUANT_OVF_STATS_EN to count overflowed channels per spectrum.
module requant_pipe #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 8,
    parameter int GAIN_W   = 5,
    parameter int SHIFT    = 4,
    parameter int N_CHAN   = 2048,
    parameter int GAIN_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    requant_pipe_if.slave bus
);
    localparam int ADDR_W = $clog2(N_CHAN);
    localparam int P_W    = IN_W + GAIN_W + 1;
    localparam logic signed [P_W:0] RND  = (SHIFT > 0) ? (P_W+1)'(2 ** (SHIFT - 1)) : '0;
    localparam logic signed [P_W:0] MAXV = (P_W+1)'(2 ** (OUT_W - 1) - 1);

    typedef enum logic [1:0] {WAIT_ARM, WAIT_SYNC, RUNNING} state_t;

    typedef struct packed {
        logic              vld;
        logic              tok;
`ifdef REQUANT_OVF_STATS_EN
        logic              last;
`endif
        logic [2*IN_W-1:0] data;
    } smp_t;

    state_t            state, state_nx;
    logic              accept;
    logic [ADDR_W-1:0] chan_count;
    smp_t              in_s, al_s;

    always_ff @(posedge clk or posedge rst)
        if (rst)         state <= WAIT_ARM;
        else if (bus.ce) state <= state_nx;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            WAIT_ARM:  if (bus.arm) state_nx = WAIT_SYNC;
            WAIT_SYNC: if (bus.sync_in) begin
                state_nx = RUNNING;
                accept   = 1'b1;
            end
            RUNNING:   if (bus.arm) state_nx = WAIT_SYNC;
            default:   state_nx = WAIT_ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) chan_count <= '0;
        else if (bus.ce) begin
            if (accept)
                chan_count <= '0;
            else if (state == RUNNING)
                chan_count <= (chan_count == ADDR_W'(N_CHAN - 1)) ? '0 : chan_count + 1'b1;
        end

    assign bus.gain_addr = (state == RUNNING) ? chan_count : '0;

    // The sync token rides alongside the sample of the accepting cycle, which
    // is one channel ahead of channel 0, so sync_out leads it by one cycle.
    always_comb begin
        in_s      = '0;
        in_s.vld  = (state == RUNNING);
        in_s.tok  = accept;
`ifdef REQUANT_OVF_STATS_EN
        in_s.last = (state == RUNNING) && (chan_count == ADDR_W'(N_CHAN - 1));
`endif
        in_s.data = bus.data_in;
    end

    generate
        if (GAIN_LAT == 0) begin : g_nodly
            assign al_s = in_s;
        end else begin : g_dly
            smp_t dly_q [GAIN_LAT];
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int i = 0; i < GAIN_LAT; i++) dly_q[i] <= '0;
                end else if (bus.ce) begin
                    dly_q[0] <= in_s;
                    for (int i = 1; i < GAIN_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            assign al_s = dly_q[GAIN_LAT-1];
        end
    endgenerate

    logic signed [IN_W-1:0]  al_re, al_im;
    logic signed [GAIN_W:0]  g_s;
    logic                    vld_m, tok_m;
    logic signed [P_W-1:0]   p_re, p_im;
`ifdef REQUANT_OVF_STATS_EN
    logic                    last_m;
`endif

    assign al_re = al_s.data[2*IN_W-1:IN_W];
    assign al_im = al_s.data[IN_W-1:0];
    assign g_s   = {1'b0, bus.gain};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vld_m <= 1'b0;
            tok_m <= 1'b0;
            p_re  <= '0;
            p_im  <= '0;
`ifdef REQUANT_OVF_STATS_EN
            last_m <= 1'b0;
`endif
        end else if (bus.ce) begin
            vld_m <= al_s.vld;
            tok_m <= al_s.tok;
            p_re  <= P_W'(al_re) * P_W'(g_s);
            p_im  <= P_W'(al_im) * P_W'(g_s);
`ifdef REQUANT_OVF_STATS_EN
            last_m <= al_s.last;
`endif
        end

    // Returns {clipped, value}; the clip is symmetric so -2^(OUT_W-1) never appears.
    function automatic logic [OUT_W:0] sat(input logic signed [P_W-1:0] p);
        logic signed [P_W:0] r;
        r = ((P_W+1)'(p) + RND) >>> SHIFT;
        if (r > MAXV)  return {1'b1, OUT_W'(MAXV)};
        if (r < -MAXV) return {1'b1, OUT_W'(-MAXV)};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic [OUT_W:0]     q_re, q_im;
    logic               ovf_nx;
    logic [2*OUT_W-1:0] dout_q;
    logic               valid_q, sync_q, ovf_q;

    assign q_re   = sat(p_re);
    assign q_im   = sat(p_im);
    assign ovf_nx = vld_m & (q_re[OUT_W] | q_im[OUT_W]);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.ce) begin
            dout_q  <= vld_m ? {q_re[OUT_W-1:0], q_im[OUT_W-1:0]} : '0;
            valid_q <= vld_m;
            sync_q  <= tok_m;
            ovf_q   <= ovf_nx;
        end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.sync_out   = sync_q;
    assign bus.overflow   = ovf_q;

`ifdef REQUANT_OVF_STATS_EN
    logic [ADDR_W:0] ovf_acc, ovf_cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ovf_acc   <= '0;
            ovf_cnt_q <= '0;
        end else if (bus.ce) begin
            if (tok_m)
                ovf_acc <= '0;
            else if (vld_m && last_m) begin
                ovf_cnt_q <= ovf_acc + (ADDR_W+1)'(ovf_nx);
                ovf_acc   <= '0;
            end else if (vld_m)
                ovf_acc <= ovf_acc + (ADDR_W+1)'(ovf_nx);
        end

    assign bus.ovf_count = ovf_cnt_q;
`else
    assign bus.ovf_count = '0;
`endif
endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe: N_CHAN=8, GAIN_LAT=1, SHIFT=4, 12->8 bits.
module tb_requant_pipe;
    localparam int N_CHAN = 8;
    localparam int ADDR_W = 3;
`ifdef REQUANT_OVF_STATS_EN
    localparam int OVF_EXP = 3;
`else
    localparam int OVF_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    requant_pipe_if #(.IN_W(12), .OUT_W(8), .GAIN_W(5), .ADDR_W(ADDR_W)) bus ();

    requant_pipe #(
        .IN_W(12), .OUT_W(8), .GAIN_W(5), .SHIFT(4), .N_CHAN(N_CHAN), .GAIN_LAT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Channel table: inputs, gains and hand-computed round/saturate results.
    int   gain_mem [N_CHAN] = '{1, 3, 1, 31, 16, 1, 1, 2};
    int   re_v     [N_CHAN] = '{24, 24, -24, 2047, -2048, 0, -8, 100};
    int   im_v     [N_CHAN] = '{100, 100, -2048, 0, 5, 8, 0, -100};
    int   qre      [N_CHAN] = '{2, 5, -1, 127, -127, 0, 0, 13};
    int   qim      [N_CHAN] = '{6, 19, -127, 0, 5, 1, 0, -12};
    int   ovf_e    [N_CHAN] = '{0, 0, 1, 1, 1, 0, 0, 0};

    // Gain RAM with one ce-cycle read latency.
    always @(posedge clk) if (bus.ce) bus.gain <= 5'(gain_mem[bus.gain_addr]);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pk(input int r, input int i);
        return {r[7:0], i[7:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch);
        int r, i;
        r = re_v[ch];
        i = im_v[ch];
        bus.data_in = {r[11:0], i[11:0]};
    endtask

    task automatic check_out(input int j, input int exp_sync);
        if (j >= 0) begin
            chk("data_out", 32'(bus.data_out), 32'(pk(qre[j % N_CHAN], qim[j % N_CHAN])));
            chk("data_valid", 32'(bus.data_valid), 1);
            chk("overflow", 32'(bus.overflow), ovf_e[j % N_CHAN]);
            if (j % N_CHAN == N_CHAN - 1) chk("ovf_count", 32'(bus.ovf_count), OVF_EXP);
        end else begin
            chk("idle_data_out", 32'(bus.data_out), 0);
            chk("idle_valid", 32'(bus.data_valid), 0);
            chk("idle_overflow", 32'(bus.overflow), 0);
        end
        chk("sync_out", 32'(bus.sync_out), exp_sync);
    endtask

    initial begin
        rst = 1'b1;
        bus.ce = 1'b1;
        bus.arm = 1'b0;
        bus.sync_in = 1'b0;
        bus.data_in = '0;
        #1;
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.data_valid), 0);
        chk("rst_sync", 32'(bus.sync_out), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 0);
        chk("rst_gain_addr", 32'(bus.gain_addr), 0);
        tick;
        tick;
        rst = 1'b0;

        // arm with sync in WAIT_ARM: sync must be ignored
        bus.arm = 1'b1;
        bus.sync_in = 1'b1;
        tick;
        bus.arm = 1'b0;
        bus.sync_in = 1'b0;
        tick;
        tick;
        chk("arm_sync_ignored_addr", 32'(bus.gain_addr), 0);
        chk("arm_sync_ignored_valid", 32'(bus.data_valid), 0);

        // arm alone in WAIT_SYNC changes nothing
        bus.arm = 1'b1;
        tick;
        bus.arm = 1'b0;
        tick;
        tick;
        chk("wait_sync_arm_addr", 32'(bus.gain_addr), 0);
        chk("wait_sync_arm_sync", 32'(bus.sync_out), 0);

        // sync accepted; 20 channel cycles
        bus.sync_in = 1'b1;
        tick;
        bus.sync_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(k % N_CHAN);
            chk("gain_addr", 32'(bus.gain_addr), k % N_CHAN);
            tick;
            check_out(k - 2, (k == 1) ? 1 : 0);
        end

        // re-arm with simultaneous sync while RUNNING: go to WAIT_SYNC, drain
        drive(20 % N_CHAN);
        bus.arm = 1'b1;
        bus.sync_in = 1'b1;
        chk("rearm_addr_before", 32'(bus.gain_addr), 4);
        tick;
        bus.arm = 1'b0;
        bus.sync_in = 1'b0;
        chk("rearm_addr_after", 32'(bus.gain_addr), 0);
        check_out(18, 0);
        tick;
        chk("rearm_addr_held", 32'(bus.gain_addr), 0);
        check_out(19, 0);
        tick;
        check_out(20, 0);
        tick;
        chk("drained_valid", 32'(bus.data_valid), 0);
        chk("drained_addr", 32'(bus.gain_addr), 0);

        // restart at channel 0 with ce toggling 1010...
        bus.sync_in = 1'b1;
        tick;
        bus.sync_in = 1'b0;
        for (int n = 0; n < 12; n++) begin
            bus.ce = 1'b1;
            drive(n % N_CHAN);
            chk("ce_gain_addr", 32'(bus.gain_addr), n % N_CHAN);
            tick;
            check_out(n - 2, (n == 1) ? 1 : 0);
            bus.ce = 1'b0;
            bus.data_in = 24'hABCDEF;
            bus.sync_in = 1'b1;
            tick;
            chk("ce_hold_addr", 32'(bus.gain_addr), (n + 1) % N_CHAN);
            check_out(n - 2, (n == 1) ? 1 : 0);
            bus.sync_in = 1'b0;
        end
        bus.ce = 1'b1;

        // asynchronous reset between edges, mid-spectrum
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data_out", 32'(bus.data_out), 0);
        chk("arst_valid", 32'(bus.data_valid), 0);
        chk("arst_overflow", 32'(bus.overflow), 0);
        chk("arst_gain_addr", 32'(bus.gain_addr), 0);
        chk("arst_ovf_count", 32'(bus.ovf_count), 0);
        tick;
        rst = 1'b0;
        bus.sync_in = 1'b1;
        tick;
        tick;
        tick;
        bus.sync_in = 1'b0;
        chk("post_rst_needs_arm_addr", 32'(bus.gain_addr), 0);
        chk("post_rst_needs_arm_valid", 32'(bus.data_valid), 0);
        chk("post_rst_needs_arm_sync", 32'(bus.sync_out), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
